// File: rtl/switch_bounce_gen.sv
// Switch-bounce emulator: turns a clean level into a bouncy contact signal.
// Glitch count and widths come from a free-running 8-bit LFSR.
module switch_bounce_gen #(
    parameter int unsigned MAX_BOUNCES = 6,
    parameter int unsigned MAX_HOLD    = 3,
    parameter int unsigned SETTLE_MS   = 6,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk1ms_i,
    input  logic       reset_n_i,
    input  logic       sw_in_i,
    input  logic       bounce_en_i,
    output logic       sw_out_o,
    output logic       busy_o,
    output logic [7:0] glitch_cnt_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SET_W = $clog2(SETTLE_MS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               sw_in_q;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               target_q, target_d;
    logic               sw_out_q, sw_out_d;
    logic               busy_q, busy_d;
    logic [7:0]         glitch_cnt_q, glitch_cnt_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               phase_q, phase_d;
    logic [SET_W-1:0]   settle_q, settle_d;

    logic [CNT_W-1:0]   n_c;
    logic [CNT_W-1:0]   h_c;
    logic [7:0]         glitch_inc_c;

    // Bounce count and half-period drawn from the current LFSR value
    assign n_c          = CNT_W'(1) + (lfsr_q[3:0] % CNT_W'(MAX_BOUNCES));
    assign h_c          = CNT_W'(1) + (lfsr_q[7:4] % CNT_W'(MAX_HOLD));
    assign glitch_inc_c = (glitch_cnt_q == 8'hFF) ? glitch_cnt_q : glitch_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        target_d     = target_q;
        sw_out_d     = sw_out_q;
        busy_d       = busy_q;
        glitch_cnt_d = glitch_cnt_q;
        remain_d     = remain_q;
        hold_d       = hold_q;
        phase_d      = phase_q;
        settle_d     = settle_q;

        case (state_q)
            IDLE: begin
                if (!bounce_en_i) begin
                    sw_out_d = sw_in_q;
                    busy_d   = 1'b0;
                end else if (sw_in_q != sw_out_q) begin
                    target_d = sw_in_q;
                    sw_out_d = sw_in_q;
                    remain_d = n_c;
                    hold_d   = h_c;
                    phase_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = BOUNCE;
                end
            end

            BOUNCE: begin
                if (!bounce_en_i) begin
                    sw_out_d = sw_in_q;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    // Target tracks the input; the glitch pattern is relative to it
                    target_d = sw_in_q;
                    if (hold_q == CNT_W'(1)) begin
                        if (phase_q) begin
                            sw_out_d = sw_in_q;
                            phase_d  = 1'b0;
                            hold_d   = h_c;
                        end else if (remain_q != '0) begin
                            sw_out_d     = ~sw_in_q;
                            phase_d      = 1'b1;
                            hold_d       = h_c;
                            remain_d     = remain_q - CNT_W'(1);
                            glitch_cnt_d = glitch_inc_c;
                        end else begin
                            sw_out_d = sw_in_q;
                            settle_d = SET_W'(SETTLE_MS);
                            state_d  = SETTLE;
                        end
                    end else begin
                        hold_d   = hold_q - CNT_W'(1);
                        sw_out_d = phase_q ? ~sw_in_q : sw_in_q;
                    end
                end
            end

            SETTLE: begin
                if (!bounce_en_i) begin
                    sw_out_d = sw_in_q;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (sw_in_q != target_q) begin
                    target_d = sw_in_q;
                    sw_out_d = sw_in_q;
                    remain_d = n_c;
                    hold_d   = h_c;
                    phase_d  = 1'b0;
                    state_d  = BOUNCE;
                end else if (settle_q == SET_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1ms_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            sw_in_q      <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            target_q     <= 1'b0;
            sw_out_q     <= 1'b0;
            busy_q       <= 1'b0;
            glitch_cnt_q <= 8'h00;
            remain_q     <= '0;
            hold_q       <= '0;
            phase_q      <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            sw_in_q      <= sw_in_i;
            lfsr_q       <= lfsr_d;
            target_q     <= target_d;
            sw_out_q     <= sw_out_d;
            busy_q       <= busy_d;
            glitch_cnt_q <= glitch_cnt_d;
            remain_q     <= remain_d;
            hold_q       <= hold_d;
            phase_q      <= phase_d;
            settle_q     <= settle_d;
        end
    end

    assign sw_out_o     = sw_out_q;
    assign busy_o       = busy_q;
    assign glitch_cnt_o = glitch_cnt_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: per-edge waveform-plan model, directed vectors,
// a deterministic-parameter instance and a downstream 4-sample debouncer.
module tb_switch_bounce_gen;

    localparam int MB  = 6;
    localparam int MH  = 3;
    localparam int SET = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_in, bounce_en, sw_out, busy;
    logic [7:0] gcnt;
    logic       d_sw_in, d_en, d_sw_out, d_busy;
    logic [7:0] d_gcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_bounce_gen dut (
        .clk1ms_i(clk), .reset_n_i(rst_n), .sw_in_i(sw_in), .bounce_en_i(bounce_en),
        .sw_out_o(sw_out), .busy_o(busy), .glitch_cnt_o(gcnt)
    );

    switch_bounce_gen #(.MAX_BOUNCES(1), .MAX_HOLD(1), .SETTLE_MS(4)) dut_det (
        .clk1ms_i(clk), .reset_n_i(rst_n), .sw_in_i(d_sw_in), .bounce_en_i(d_en),
        .sw_out_o(d_sw_out), .busy_o(d_busy), .glitch_cnt_o(d_gcnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string nm, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, v, lo, hi, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Whole transition as a per-edge list: bit0 inverted vs target, bit1 glitch start, bit2 settling
    task automatic build_plan(input logic [7:0] l, output int p[$]);
        logic [7:0] v;
        int n, h;
        p.delete();
        v = l;
        n = 1 + int'(l[3:0]) % MB;
        for (int s = 0; s < 1 + 2 * n; s++) begin
            h = 1 + int'(v[7:4]) % MH;
            for (int i = 0; i < h; i++) begin
                p.push_back((s % 2 == 1) ? ((i == 0) ? 3 : 1) : 0);
                v = lfsr_nxt(v);
            end
        end
        for (int s = 0; s < SET; s++) p.push_back(4);
    endtask

    logic       m_sync = 1'b0, m_out = 1'b0, m_busy = 1'b0, m_settle = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;
    int         m_cnt = 0;
    int         plan[$];
    int         e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync = 1'b0; m_lfsr = 8'hA5; m_out = 1'b0; m_busy = 1'b0;
            m_cnt = 0; m_settle = 1'b0; plan.delete();
        end else begin
            if (!bounce_en) begin
                m_out = m_sync; m_busy = 1'b0; m_settle = 1'b0; plan.delete();
            end else if (plan.size() == 0 && m_sync == m_out) begin
                m_busy = 1'b0; m_settle = 1'b0;
            end else begin
                if (plan.size() == 0 || (m_settle && m_sync != m_out)) build_plan(m_lfsr, plan);
                e = plan.pop_front();
                m_out = m_sync ^ e[0];
                if (e[1] && m_cnt < 255) m_cnt++;
                m_busy = 1'b1;
                m_settle = e[2];
            end
            m_sync = sw_in;
            m_lfsr = lfsr_nxt(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model_sw_out", sw_out, m_out);
            check("model_busy", busy, m_busy);
            check("model_glitch_cnt", gcnt, m_cnt);
        end
    end

    // Downstream 4-sample debouncer
    logic [3:0] deb_sh = 4'h0;
    logic       deb = 1'b0;
    always @(posedge clk) begin
        deb_sh <= {deb_sh[2:0], sw_out};
        if (deb_sh == 4'hF) deb <= 1'b1;
        else if (deb_sh == 4'h0) deb <= 1'b0;
    end

    // Episode properties while random toggles run
    logic prop_on = 1'b0, prev_busy = 1'b0, prev_out = 1'b0;
    int   run_len = 0, ep_g = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && prop_on) begin
            if (busy && !prev_busy) begin
                run_len = 1; ep_g = 0;
            end else if (busy) begin
                if (sw_out != prev_out) begin
                    check_rng("pulse_width", run_len, 1, MH);
                    run_len = 1;
                    if (sw_out != sw_in) ep_g++;
                end else begin
                    run_len++;
                end
            end else if (prev_busy) begin
                check_rng("settle_len", run_len, SET, 1000);
                check_rng("glitches_per_edge", ep_g, 1, MB);
                check("settle_level", sw_out, sw_in);
            end
        end
        prev_busy = busy;
        prev_out  = sw_out;
    end

    task automatic wait_busy(input logic lvl, input int max, input string nm);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        check(nm, busy, lvl);
    endtask

    int pq[$];
    int d_out[10]  = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int d_bsy[10]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        rst_n = 1'b0; sw_in = 1'b0; bounce_en = 1'b0; d_sw_in = 1'b0; d_en = 1'b1;

        // Pin the model: A5 -> 4A, first plan from A5 is N=6, H=2,1,3,...
        check("pin_lfsr_step", lfsr_nxt(8'hA5), 8'h4A);
        build_plan(8'hA5, pq);
        check("pin_plan0", pq[0], 0);
        check("pin_plan1", pq[1], 0);
        check("pin_plan2", pq[2], 3);
        check("pin_plan3", pq[3], 0);
        check("pin_plan5", pq[5], 0);
        check("pin_plan6", pq[6], 3);
        check("pin_plan_last", pq[pq.size() - 1], 4);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_sw_out", sw_out, 0);
        check("reset_busy", busy, 0);
        check("reset_gcnt", gcnt, 0);
        check("reset_det_gcnt", d_gcnt, 0);

        // Bypass: two-edge latency, no busy, no glitches
        sw_in = 1'b1;
        @(negedge clk);
        check("bypass_edge_k", sw_out, 0);
        @(negedge clk);
        check("bypass_edge_k1", sw_out, 1);
        check("bypass_busy", busy, 0);
        check("bypass_gcnt", gcnt, 0);
        sw_in = 1'b0;
        repeat (3) @(negedge clk);

        // Deterministic instance: one glitch, four settle edges
        d_sw_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("det_out_k%0d", i), d_sw_out, d_out[i]);
            check($sformatf("det_busy_k%0d", i), d_busy, d_bsy[i]);
        end
        check("det_gcnt", d_gcnt, 1);

        // BounceEn dropped mid-bounce
        bounce_en = 1'b1; sw_in = 1'b1;
        wait_busy(1'b1, 10, "abort_start");
        @(negedge clk);
        bounce_en = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out", sw_out, 1);
        bounce_en = 1'b1;
        repeat (5) @(negedge clk);

        // Input reversal during BOUNCE, then during SETTLE
        sw_in = 1'b0;
        wait_busy(1'b1, 10, "mid_pre_start");
        wait_busy(1'b0, 100, "mid_pre_done");
        check("mid_pre_out", sw_out, 0);
        sw_in = 1'b1;
        wait_busy(1'b1, 10, "mid_start");
        sw_in = 1'b0;
        begin
            int n = 0;
            while (!m_settle && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_reach_settle", m_settle, 1);
        check("mid_settle_out", sw_out, 0);
        check("mid_settle_busy", busy, 1);
        sw_in = 1'b1;
        wait_busy(1'b0, 200, "mid_done");
        check("mid_final_out", sw_out, 1);

        // Async reset mid-bounce, then LFSR restart from A5 gives N=5 on the first transition
        sw_in = 1'b0;
        wait_busy(1'b1, 10, "rst_start");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", sw_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_gcnt", gcnt, 0);
        @(negedge clk);
        rst_n = 1'b1; sw_in = 1'b1;
        @(negedge clk);
        check("post_rst_e1_busy", busy, 0);
        @(negedge clk);
        check("post_rst_e2_busy", busy, 1);
        wait_busy(1'b0, 100, "post_rst_done");
        check("post_rst_glitches", gcnt, 5);
        repeat (3) @(negedge clk);

        // Long toggle run with properties, debouncer and saturation
        prop_on = 1'b1;
        repeat (200) begin
            @(negedge clk);
            sw_in = ~sw_in;
            repeat ($urandom_range(120, 140)) @(negedge clk);
            check("debounced", deb, sw_in);
        end
        prop_on = 1'b0;
        check("glitch_saturated", gcnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
